slc3_mem_ctrl: RTL and testbench
================================

Name: slc3_mem_ctrl

Overview:
- Parametrised SRAM and memory-mapped I/O access sequencer for the SLC-3 CPU. It replaces the fixed single-cycle memory hookup with a request/response handshake, configurable SRAM wait states and a generalised I/O register.
- Sits between the CPU datapath (MAR/MDR side) and the external async SRAM plus its tristate buffer.

Parameters:
- DATA_W, 16, data word width.
- CPU_ADDR_W, 16, CPU address width.
- ADDR_W, 20, external SRAM address width; must be >= CPU_ADDR_W; upper bits zero-filled.
- WAIT_CYCLES, 2, SRAM access cycles with strobes asserted; legal range >= 1.
- IO_ADDR, 16'hFFFF, CPU address decoded as the I/O register.
- HEX_DIGITS, 4, number of 4-bit hex nibbles in the I/O output register; 4*HEX_DIGITS must be <= DATA_W.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU access request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  CPU_ADDR_W  access address.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  controller can accept a request.
- resp_valid  out  1  one-cycle completion pulse; rdata valid for reads.
- resp_rdata  out  DATA_W  read data.
- Switches  in  DATA_W  board switches.
- hex_out  out  4*HEX_DIGITS  I/O display register.
- CE, OE, WE, UB, LB  out  1 each  SRAM strobes, active low.
- ADDR  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  data to tristate buffer.
- sram_rdata  in  DATA_W  data from tristate buffer.
- sram_drive  out  1  tristate output enable (1 = drive bus).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- **Reset:**
  - state = IDLE; CE = OE = WE = UB = LB = 1.
  - ADDR = 0, sram_drive = 0, sram_wdata = 0.
  - resp_valid = 0, resp_rdata = 0, hex_out = 0, busy = 0.
  - Reset mid-access aborts it: no resp_valid is produced and the strobes deassert on the next edge.
- **Handshake:**
  - req_ready = 1 only in IDLE and not in reset.
  - A request is accepted on a rising edge with req_valid & req_ready; addr, we and wdata are latched at that edge.
  - Requests outside IDLE are ignored; there is no queueing.
- **States:** IDLE, SETUP, ACCESS, DONE.
- **SRAM path (req_addr != IO_ADDR):**
  - IDLE -> SETUP on accept.
  - SETUP (1 cycle): ADDR = latched addr; CE = 0; OE = 0 if read; for a write, sram_drive = 1 and sram_wdata valid, WE still 1.
  - ACCESS (WAIT_CYCLES cycles, down-counter): CE = 0; read keeps OE = 0; write drives WE = 0 and sram_drive = 1.
  - Read data is captured from sram_rdata on the edge leaving the final ACCESS cycle.
  - DONE (1 cycle): WE = 1, OE = 1, CE = 1; write keeps sram_drive = 1 for hold time; resp_valid = 1.
  - DONE -> IDLE.
  - Latency: resp_valid is high in cycle accept+WAIT_CYCLES+2, where the accept edge ends cycle 0.
  - UB = LB = 0 whenever CE = 0.
- **I/O path (req_addr == IO_ADDR):**
  - IDLE -> DONE; no SRAM strobes asserted; sram_drive = 0.
  - Read: resp_rdata = registered Switches, sampled every cycle and taken at the accept edge.
  - Write: hex_out <= req_wdata[4*HEX_DIGITS-1:0] at the accept edge.
  - resp_valid is asserted the cycle after accept.
- resp_rdata holds its last value until the next read completes; writes do not change it.
- Back-to-back: req_ready re-asserts in the cycle after DONE. Minimum request spacing is WAIT_CYCLES+3 cycles for SRAM and 2 cycles for I/O.
- busy = (state != IDLE).

Optional Feature:
- SLC3_MEM_BYTE_EN
- **Defined:**
  - Adds input req_be [1:0], latched at accept.
  - During CE = 0, UB = ~be[1] and LB = ~be[0].
  - An I/O write updates only the enabled bytes of hex_out.
  - req_be = 2'b00 completes normally with UB = LB = 1.
  - Requires DATA_W = 16.
- **Undefined:** no req_be port; UB = LB = 0 during any SRAM access.

Test Plan:
- Reset, then read 0x0010 with sram_rdata = 16'h1234, WAIT_CYCLES = 2 -> OE/CE low in cycles 1-3, resp_valid only in cycle 4, resp_rdata = 16'h1234, ADDR = 20'h00010.
- Write 0x0020 with data 16'hBEEF -> sram_drive high cycles 1-4, WE low exactly cycles 2-3, ADDR = 20'h00020, resp_valid in cycle 4.
- Write IO_ADDR with 16'hCAFE -> hex_out = 16'hCAFE one cycle after accept, no CE/OE/WE activity. Then read IO_ADDR with Switches = 16'h00A5 -> resp_rdata = 16'h00A5 with resp_valid at accept+1.
- Pulse Reset during ACCESS of a write -> next cycle WE = CE = 1, sram_drive = 0, no resp_valid, req_ready = 1 after reset release.
- Hold req_valid high continuously with alternating addresses -> exactly one acceptance per WAIT_CYCLES+3 cycles, no acceptance while busy = 1.
- With SLC3_MEM_BYTE_EN and req_be = 2'b10 on an SRAM write -> UB = 0, LB = 1 during CE = 0.

Source files
------------

// File: rtl/slc3_mem_ctrl_if.sv
// CPU-side request/response bus for slc3_mem_ctrl.
// Carries req_be only when SLC3_MEM_BYTE_EN is defined.
interface slc3_mem_ctrl_if #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned CPU_ADDR_W = 16
);
    logic                  req_valid;
    logic                  req_we;
    logic [CPU_ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
`ifdef SLC3_MEM_BYTE_EN
    logic [1:0]            req_be;

    modport master (output req_valid, req_we, req_addr, req_wdata, req_be,
                    input  req_ready, resp_valid, resp_rdata);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_be,
                    output req_ready, resp_valid, resp_rdata);
`else
    modport master (output req_valid, req_we, req_addr, req_wdata,
                    input  req_ready, resp_valid, resp_rdata);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                    output req_ready, resp_valid, resp_rdata);
`endif
endinterface

// File: rtl/slc3_mem_ctrl.sv
// SLC-3 SRAM / memory-mapped I/O access sequencer with configurable wait states.
// Optional byte enables via the SLC3_MEM_BYTE_EN macro.
module slc3_mem_ctrl #(
    parameter int unsigned           DATA_W      = 16,
    parameter int unsigned           CPU_ADDR_W  = 16,
    parameter int unsigned           ADDR_W      = 20,
    parameter int unsigned           WAIT_CYCLES = 2,
    parameter logic [CPU_ADDR_W-1:0] IO_ADDR     = 16'hFFFF,
    parameter int unsigned           HEX_DIGITS  = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    slc3_mem_ctrl_if.slave          bus,
    input  logic [DATA_W-1:0]       Switches,
    output logic [4*HEX_DIGITS-1:0] hex_out,
    output logic                    CE,
    output logic                    OE,
    output logic                    WE,
    output logic                    UB,
    output logic                    LB,
    output logic [ADDR_W-1:0]       ADDR,
    output logic [DATA_W-1:0]       sram_wdata,
    input  logic [DATA_W-1:0]       sram_rdata,
    output logic                    sram_drive,
    output logic                    busy
);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               write_q;
    logic [DATA_W-1:0]  switches_q;
    logic [4*HEX_DIGITS-1:0] hex_next;

    assign bus.req_ready = (state == IDLE) && !Reset;
    assign busy          = (state != IDLE);

`ifdef SLC3_MEM_BYTE_EN
    // Each hex bit belongs to the byte lane that carries it on the data bus.
    always_comb begin
        hex_next = hex_out;
        for (int unsigned i = 0; i < 4*HEX_DIGITS; i++) begin
            if (bus.req_be[i/8])
                hex_next[i] = bus.req_wdata[i];
        end
    end
`else
    assign hex_next = bus.req_wdata[4*HEX_DIGITS-1:0];
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            cnt            <= '0;
            write_q        <= 1'b0;
            switches_q     <= '0;
            CE             <= 1'b1;
            OE             <= 1'b1;
            WE             <= 1'b1;
            UB             <= 1'b1;
            LB             <= 1'b1;
            ADDR           <= '0;
            sram_wdata     <= '0;
            sram_drive     <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            hex_out        <= '0;
        end else begin
            switches_q <= Switches;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q <= bus.req_we;
                        if (bus.req_addr == IO_ADDR) begin
                            state          <= DONE;
                            bus.resp_valid <= 1'b1;
                            if (bus.req_we)
                                hex_out <= hex_next;
                            else
                                bus.resp_rdata <= switches_q;
                        end else begin
                            state <= SETUP;
                            ADDR  <= ADDR_W'(bus.req_addr);
                            CE    <= 1'b0;
                            OE    <= bus.req_we;
`ifdef SLC3_MEM_BYTE_EN
                            UB    <= ~bus.req_be[1];
                            LB    <= ~bus.req_be[0];
`else
                            UB    <= 1'b0;
                            LB    <= 1'b0;
`endif
                            if (bus.req_we) begin
                                sram_drive <= 1'b1;
                                sram_wdata <= bus.req_wdata;
                            end
                        end
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= CNT_W'(WAIT_CYCLES - 1);
                    if (write_q)
                        WE <= 1'b0;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state          <= DONE;
                        CE             <= 1'b1;
                        OE             <= 1'b1;
                        WE             <= 1'b1;
                        UB             <= 1'b1;
                        LB             <= 1'b1;
                        bus.resp_valid <= 1'b1;
                        if (!write_q)
                            bus.resp_rdata <= sram_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    sram_drive     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Self-checking bench for slc3_mem_ctrl: cycle-schedule checks plus a
// behavioural SRAM and a write/read scoreboard.
module tb_slc3_mem_ctrl;
    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Switches = '0;
    logic [15:0] hex_out;
    logic        CE, OE, WE, UB, LB;
    logic [19:0] ADDR;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_drive, busy;

    int checks = 0;
    int fails  = 0;

    logic [15:0] sram_mem [0:65535];
    logic [15:0] ref_mem  [logic [15:0]];
    logic [15:0] hex_ref  = '0;
    logic [15:0] last_rd  = '0;

    slc3_mem_ctrl_if #(.DATA_W(16), .CPU_ADDR_W(16)) bus();

    slc3_mem_ctrl #(
        .DATA_W(16), .CPU_ADDR_W(16), .ADDR_W(20), .WAIT_CYCLES(W),
        .IO_ADDR(16'hFFFF), .HEX_DIGITS(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus.slave), .Switches(Switches),
        .hex_out(hex_out), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
        .ADDR(ADDR), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_drive(sram_drive), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Behavioural async SRAM: writes while CE and WE are low, drives data while CE and OE are low.
    always @(posedge Clk) if (!CE && !WE) sram_mem[ADDR[15:0]] = sram_wdata;
    assign sram_rdata = (!CE && !OE) ? sram_mem[ADDR[15:0]] : 16'h0BAD;

    // One SRAM transaction; every cycle's strobe vector is checked against the timing rules.
    task automatic sram_access(input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata, output logic [15:0] rdata);
        logic [8:0] got, exp;
        logic ce_on;
        rdata = 'x;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge Clk);
            bus.req_valid = 1'b0;
            ce_on = (k <= W + 1);
            exp = {!ce_on, !(ce_on && !we), !(we && k >= 2 && k <= W + 1),
                   !ce_on, !ce_on, we && (k <= W + 2), k == W + 2,
                   k <= W + 2, k > W + 2};
            got = {CE, OE, WE, UB, LB, sram_drive, bus.resp_valid, busy, bus.req_ready};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL sram_strobes addr=%h we=%0d cycle=%0d: got %b expected %b",
                         addr, we, k, got, exp);
            end
            if (!CE) begin
                checks++;
                if (ADDR !== {4'h0, addr}) begin
                    fails++;
                    $display("FAIL sram_addr cycle=%0d: got %h expected %h", k, ADDR, {4'h0, addr});
                end
            end
            if (bus.resp_valid) rdata = bus.resp_rdata;
        end
    endtask

    task automatic io_access(input logic we, input logic [15:0] wdata, output logic [15:0] rdata);
        logic [8:0] got;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = 16'hFFFF;
        bus.req_wdata = wdata;
        @(negedge Clk);
        bus.req_valid = 1'b0;
        got = {CE, OE, WE, UB, LB, sram_drive, bus.resp_valid, busy, bus.req_ready};
        checks++;
        if (got !== 9'b11111_0110) begin
            fails++;
            $display("FAIL io_cycle1 we=%0d: got %b expected %b", we, got, 9'b11111_0110);
        end
        if (we) begin
            checks++;
            if (hex_out !== hex_ref) begin
                fails++;
                $display("FAIL io_hex_out: got %h expected %h", hex_out, hex_ref);
            end
        end
        rdata = bus.resp_rdata;
        @(negedge Clk);
        got = {CE, OE, WE, UB, LB, sram_drive, bus.resp_valid, busy, bus.req_ready};
        checks++;
        if (got !== 9'b11111_0001) begin
            fails++;
            $display("FAIL io_cycle2 we=%0d: got %b expected %b", we, got, 9'b11111_0001);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if ({CE, OE, WE, UB, LB, sram_drive, bus.resp_valid, busy, bus.req_ready} !== 9'b11111_0000) begin
            fails++;
            $display("FAIL reset_strobes: got %b expected %b",
                     {CE, OE, WE, UB, LB, sram_drive, bus.resp_valid, busy, bus.req_ready}, 9'b11111_0000);
        end
        checks++;
        if ({ADDR, sram_wdata, bus.resp_rdata, hex_out} !== '0) begin
            fails++;
            $display("FAIL reset_regs: got addr=%h wdata=%h rdata=%h hex=%h expected all zero",
                     ADDR, sram_wdata, bus.resp_rdata, hex_out);
        end
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if ({bus.req_ready, busy} !== 2'b10) begin
            fails++;
            $display("FAIL reset_release: got ready/busy %b expected 10", {bus.req_ready, busy});
        end
    endtask

    task automatic test_sram_read();
        logic [15:0] rd;
        sram_mem[16'h0010] = 16'h1234;
        sram_access(1'b0, 16'h0010, 16'h0000, rd);
        last_rd = 16'h1234;
        checks++;
        if (rd !== 16'h1234) begin
            fails++;
            $display("FAIL sram_read_data: got %h expected %h", rd, 16'h1234);
        end
    endtask

    task automatic test_sram_write();
        logic [15:0] rd;
        sram_access(1'b1, 16'h0020, 16'hBEEF, rd);
        ref_mem[16'h0020] = 16'hBEEF;
        checks++;
        if (sram_mem[16'h0020] !== 16'hBEEF) begin
            fails++;
            $display("FAIL sram_write_mem: got %h expected %h", sram_mem[16'h0020], 16'hBEEF);
        end
        checks++;
        if (bus.resp_rdata !== last_rd) begin
            fails++;
            $display("FAIL rdata_hold_after_write: got %h expected %h", bus.resp_rdata, last_rd);
        end
    endtask

    task automatic test_random_sram();
        logic [15:0] keys [$];
        logic [15:0] a, d, rd;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom_range(0, 16'hFFFE));
            d = 16'($urandom);
            sram_access(1'b1, a, d, rd);
            ref_mem[a] = d;
            keys.push_back(a);
            a = keys[$urandom_range(0, keys.size() - 1)];
            sram_access(1'b0, a, 16'h0000, rd);
            last_rd = ref_mem[a];
            checks++;
            if (rd !== ref_mem[a]) begin
                fails++;
                $display("FAIL random_readback addr=%h: got %h expected %h", a, rd, ref_mem[a]);
            end
        end
    endtask

    task automatic test_io();
        logic [15:0] rd;
        hex_ref = 16'hCAFE;
        io_access(1'b1, 16'hCAFE, rd);
        Switches = 16'h00A5;
        @(negedge Clk);
        io_access(1'b0, 16'h0000, rd);
        last_rd = 16'h00A5;
        checks++;
        if (rd !== 16'h00A5) begin
            fails++;
            $display("FAIL io_read_switches: got %h expected %h", rd, 16'h00A5);
        end
        for (int i = 0; i < 4; i++) begin
            hex_ref = 16'($urandom);
            io_access(1'b1, hex_ref, rd);
            checks++;
            if (bus.resp_rdata !== last_rd) begin
                fails++;
                $display("FAIL io_rdata_hold: got %h expected %h", bus.resp_rdata, last_rd);
            end
            Switches = 16'($urandom);
            @(negedge Clk);
            io_access(1'b0, 16'h0000, rd);
            last_rd = Switches;
            checks++;
            if (rd !== Switches) begin
                fails++;
                $display("FAIL io_random_read: got %h expected %h", rd, Switches);
            end
        end
    endtask

    task automatic test_reset_abort();
        int rv_seen = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0040;
        bus.req_wdata = 16'h1111;
        @(negedge Clk);
        bus.req_valid = 1'b0;
        @(negedge Clk);
        checks++;
        if ({CE, WE} !== 2'b00) begin
            fails++;
            $display("FAIL abort_in_access: got CE/WE %b expected 00", {CE, WE});
        end
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if ({CE, WE, sram_drive, bus.resp_valid, busy} !== 5'b11000) begin
            fails++;
            $display("FAIL abort_strobes: got %b expected %b",
                     {CE, WE, sram_drive, bus.resp_valid, busy}, 5'b11000);
        end
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_ready: got %b expected 1", bus.req_ready);
        end
        for (int i = 0; i < W + 3; i++) begin
            if (bus.resp_valid) rv_seen++;
            @(negedge Clk);
        end
        checks++;
        if (rv_seen != 0) begin
            fails++;
            $display("FAIL abort_no_resp: got %0d responses expected 0", rv_seen);
        end
        hex_ref = '0;
        last_rd = '0;
    endtask

    task automatic test_back_to_back();
        int          accepts [$];
        logic [15:0] exp_q [$];
        logic [15:0] cur = 16'h0030;
        int          viol = 0;
        int          resps = 0;
        sram_mem[16'h0030] = 16'hA0A0;
        sram_mem[16'h0031] = 16'h5151;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = cur;
        for (int c = 0; c < 4 * (W + 3) + W + 3; c++) begin
            if (c == 4 * (W + 3)) bus.req_valid = 1'b0;
            if (bus.req_ready && busy) viol++;
            if (bus.resp_valid) begin
                resps++;
                checks++;
                if (exp_q.size() == 0 || bus.resp_rdata !== exp_q[0]) begin
                    fails++;
                    $display("FAIL b2b_rdata cycle=%0d: got %h expected %h", c, bus.resp_rdata,
                             exp_q.size() ? exp_q[0] : 16'hxxxx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus.req_ready && bus.req_valid) begin
                accepts.push_back(c);
                exp_q.push_back(sram_mem[cur]);
                cur = cur ^ 16'h0001;
            end
            @(negedge Clk);
            bus.req_addr = cur;
        end
        checks++;
        if (accepts.size() != 4) begin
            fails++;
            $display("FAIL b2b_accept_count: got %0d expected 4", accepts.size());
        end
        for (int i = 1; i < accepts.size(); i++) begin
            checks++;
            if (accepts[i] - accepts[i-1] != W + 3) begin
                fails++;
                $display("FAIL b2b_spacing: got %0d expected %0d", accepts[i] - accepts[i-1], W + 3);
            end
        end
        checks++;
        if (viol != 0 || resps != 4) begin
            fails++;
            $display("FAIL b2b_busy_resp: got viol=%0d resps=%0d expected viol=0 resps=4", viol, resps);
        end
        last_rd = (cur == 16'h0030) ? 16'h5151 : 16'hA0A0;
    endtask

`ifdef SLC3_MEM_BYTE_EN
    task automatic test_byte_en();
        logic [15:0] rd;
        bus.req_be    = 2'b10;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0050;
        bus.req_wdata = 16'h7777;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge Clk);
            bus.req_valid = 1'b0;
            if (!CE) begin
                checks++;
                if ({UB, LB} !== 2'b01) begin
                    fails++;
                    $display("FAIL be_lanes cycle=%0d: got %b expected 01", k, {UB, LB});
                end
            end
        end
        bus.req_be = 2'b01;
        hex_ref = {hex_ref[15:8], 8'h3C};
        io_access(1'b1, 16'hAA3C, rd);
        bus.req_be = 2'b11;
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef SLC3_MEM_BYTE_EN
        bus.req_be    = 2'b11;
`endif
        test_reset();
        test_sram_read();
        test_sram_write();
        test_io();
        test_random_sram();
        test_reset_abort();
        test_back_to_back();
`ifdef SLC3_MEM_BYTE_EN
        test_byte_en();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
